// File: rtl/spi_pkg.sv
// Shared types for the SPI transfer engine: FSM states and SPI mode encoding.
package spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_PUSH,
        S_HOLD
    } state_t;

    typedef logic [1:0] spi_mode_t;

    localparam int MODE_CPHA = 0;
    localparam int MODE_CPOL = 1;

    function automatic spi_mode_t spi_mode(input logic cpol, input logic cpha);
        return {cpol, cpha};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: one tick every clk_div_i+1 cycles, split into lead/trail
// edge pulses while shifting.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [DIV_WIDTH-1:0] clk_div_i,
    input  logic                 shift_en,
    input  logic                 hold_en,
    output logic                 tick,
    output logic                 lead,
    output logic                 trail
);

    logic [DIV_WIDTH-1:0] cnt;
    logic                 phase;
    logic                 run;

    assign run   = shift_en | hold_en;
    assign tick  = run && (cnt == clk_div_i);
    assign lead  = tick & shift_en & ~phase;
    assign trail = tick & shift_en & phase;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else begin
            if (!run || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // phase 0 = next edge leaves idle level, 1 = returns to it
            if (!shift_en) begin
                phase <= 1'b0;
            end else if (tick) begin
                phase <= ~phase;
            end
        end
    end

endmodule

// File: rtl/spi_xfer_engine.sv
// SPI master frame engine between a TX FIFO and an RX FIFO.
// Optional SPI_XFER_LOOPBACK_EN adds loopback_i (sample mosi_o instead of miso_i).
module spi_xfer_engine
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  enable_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic [DIV_WIDTH-1:0]  clk_div_i,
    input  logic                  tx_empty_i,
    input  logic [DATA_WIDTH-1:0] tx_rdata_i,
    output logic                  tx_rd_o,
    input  logic                  rx_full_i,
    output logic                  rx_wr_o,
    output logic [DATA_WIDTH-1:0] rx_wdata_o,
    output logic                  sclk_o,
    output logic                  mosi_o,
    input  logic                  miso_i,
`ifdef SPI_XFER_LOOPBACK_EN
    input  logic                  loopback_i,
`endif
    output logic                  csn_o,
    output logic                  busy_o
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] NBITS = CW'(DATA_WIDTH);

    state_t                state;
    spi_mode_t             mode_q;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [CW-1:0]         bitcnt;
    logic                  tick;
    logic                  lead;
    logic                  trail;
    logic                  sdi;
    logic                  cpha;
    logic                  next_ok;

    assign cpha    = mode_q[MODE_CPHA];
    assign next_ok = enable_i & ~tx_empty_i;
    assign mosi_o  = tx_sr[DATA_WIDTH-1];
    assign busy_o  = (state != S_IDLE);

`ifdef SPI_XFER_LOOPBACK_EN
    assign sdi = loopback_i ? mosi_o : miso_i;
`else
    assign sdi = miso_i;
`endif

    spi_sclk_gen #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_sclk (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clk_div_i(clk_div_i),
        .shift_en (state == S_SHIFT),
        .hold_en  (state == S_HOLD),
        .tick     (tick),
        .lead     (lead),
        .trail    (trail)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= S_IDLE;
            mode_q     <= '0;
            sclk_o     <= 1'b0;
            csn_o      <= 1'b1;
            tx_sr      <= '0;
            rx_sr      <= '0;
            bitcnt     <= '0;
            tx_rd_o    <= 1'b0;
            rx_wr_o    <= 1'b0;
            rx_wdata_o <= '0;
        end else begin
            tx_rd_o <= 1'b0;
            rx_wr_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    mode_q <= spi_mode(cpol_i, cpha_i);
                    sclk_o <= cpol_i;
                    if (next_ok) begin
                        csn_o   <= 1'b0;
                        tx_rd_o <= 1'b1;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    tx_sr  <= tx_rdata_i;
                    rx_sr  <= '0;
                    bitcnt <= NBITS;
                    state  <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (lead) begin
                        sclk_o <= ~sclk_o;
                        if (!cpha) begin
                            rx_sr <= {rx_sr[DATA_WIDTH-2:0], sdi};
                        end else if (bitcnt != NBITS) begin
                            // CPHA=1: MSB is already on mosi for the first lead edge
                            tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                        end
                    end else if (trail) begin
                        sclk_o <= ~sclk_o;
                        bitcnt <= bitcnt - CW'(1);
                        if (cpha) begin
                            rx_sr <= {rx_sr[DATA_WIDTH-2:0], sdi};
                        end else begin
                            tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                        end
                        if (bitcnt == CW'(1)) begin
                            state <= S_PUSH;
                        end
                    end
                end
                S_PUSH: begin
                    sclk_o <= mode_q[MODE_CPOL];
                    if (!rx_full_i) begin
                        rx_wr_o    <= 1'b1;
                        rx_wdata_o <= rx_sr;
                        if (next_ok) begin
                            tx_rd_o <= 1'b1;
                            state   <= S_LOAD;
                        end else begin
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        csn_o <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
